// File: rtl/bcd_add_seq.sv
// bcd_add_seq: word-serial multi-word BCD adder sequencer.
// A job of `len` 16-bit BCD word pairs streams in least-significant word
// first. The decimal carry chains from word to word through one 4-digit
// adder, and the sum words stream out with a final carry.
// Optional macro BCD_SUB_EN adds subtract mode (A - B in ten's complement).
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// Valid never waits on ready, and ready never depends on valid. While
// out_valid=1 && out_ready=0, out_sum/out_last/out_valid hold stable.

// Four-digit BCD adder, ripple of per-digit decimal adders.
module bcd_adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [4:0] t;
    logic       c;

    // Per-digit binary add followed by +6 correction when the digit exceeds 9.
    always_comb begin
        sum = '0;
        c   = cin;
        t   = '0;
        for (int i = 0; i < 4; i++) begin
            t = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, c};
            if (t > 5'd9) begin
                t = t + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            sum[4*i +: 4] = t[3:0];
        end
        cout = c;
    end
endmodule

module bcd_add_seq #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             cin_init,
    input  logic             sub,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sum,
    output logic             out_last,
    output logic             done,
    output logic             carry_out,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic [15:0]      out_sum_q, out_sum_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             done_q, done_d;
    logic             carry_out_q, carry_out_d;

    logic             sub_req;
    logic [15:0]      adder_b;
    logic [15:0]      adder_sum;
    logic             adder_cout;
    logic             start_ok;
    logic             accept;
    logic             consumed;

`ifdef BCD_SUB_EN
    logic [15:0] b_nines;

    // Nine's complement of each digit of operand B.
    always_comb begin
        b_nines = '0;
        for (int i = 0; i < 4; i++) begin
            b_nines[4*i +: 4] = 4'd9 - in_b[4*i +: 4];
        end
    end

    assign sub_req = sub;
    assign adder_b = sub_q ? b_nines : in_b;
`else
    wire unused_sub = sub;

    assign sub_req = 1'b0;
    assign adder_b = in_b;
`endif

    bcd_adder16 u_adder (
        .a    (in_a),
        .b    (adder_b),
        .cin  (carry_q),
        .sum  (adder_sum),
        .cout (adder_cout)
    );

    // A start is taken only in IDLE, not in the done cycle, and never for len 0.
    assign start_ok = (state_q == S_IDLE) && start && (len != '0) && !done_q;
    assign accept   = in_valid && in_ready;
    assign consumed = out_valid_q && out_ready;

    // State register and all datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            sub_q       <= sub_d;
            out_sum_q   <= out_sum_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            carry_out_q <= carry_out_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_RUN;
            S_RUN:   if (accept && (cnt_q == CNT_ONE)) state_d = S_DRAIN;
            S_DRAIN: if (consumed) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: job capture, word accept, drain and done pulse.
    always_comb begin
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        sub_d       = sub_q;
        out_sum_d   = out_sum_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        carry_out_d = carry_out_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    cnt_d   = len;
                    sub_d   = sub_req;
                    // Subtraction is A + nines(B) + 1, so cin_init is ignored.
                    carry_d = sub_req ? 1'b1 : cin_init;
                end
            end
            S_RUN: begin
                if (accept) begin
                    out_sum_d   = adder_sum;
                    out_valid_d = 1'b1;
                    carry_d     = adder_cout;
                    cnt_d       = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) out_last_d = 1'b1;
                end else if (consumed) begin
                    out_valid_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (consumed) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                    // In subtract mode a missing carry means a borrow.
                    carry_out_d = carry_q ^ sub_q;
                end
            end
            default: ;
        endcase
    end

    // Outputs derived from state and registers.
    always_comb begin
        busy      = (state_q != S_IDLE);
        in_ready  = (state_q == S_RUN) && (!out_valid_q || out_ready);
        out_valid = out_valid_q;
        out_sum   = out_sum_q;
        out_last  = out_last_q;
        done      = done_q;
        carry_out = carry_out_q;
        dbg_state = state_q;
    end
endmodule

// File: tb/tb_bcd_add_seq.sv
// Testbench for bcd_add_seq: directed vector table, hand sequences for
// ignored starts and mid-job reset, then randomized jobs against a
// decimal-arithmetic reference model.
`timescale 1ns/1ps
module tb_bcd_add_seq;
    localparam int LEN_W = 4;
`ifdef BCD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             cin_init;
    logic             sub;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_sum;
    logic             out_last;
    logic             done;
    logic             carry_out;
    logic [1:0]       dbg_state;

    bcd_add_seq #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .cin_init  (cin_init),
        .sub       (sub),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .done      (done),
        .carry_out (carry_out),
        .dbg_state (dbg_state)
    );

    // Clock and reset block.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int passed = 0;

    // Scoreboard: expected {out_last, out_sum} per word, plus final carry.
    logic [16:0] exp_q[$];
    logic        exp_carry;
    logic [15:0] a_w[16];
    logic [15:0] b_w[16];

    typedef struct {
        int          n;
        bit          cin;
        bit          sb;
        int          mode;     // 0: ready always, 1: random, 2: stall 4 cycles
        bit          bstart;   // pulse start while busy
        bit          need_sub;
        logic [15:0] a[3];
        logic [15:0] b[3];
        logic [15:0] s[3];
        bit          co;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int bcd2int(input logic [15:0] w);
        int v = 0;
        for (int i = 3; i >= 0; i--) v = v * 10 + int'(w[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] w = '0;
        int x = v;
        for (int i = 0; i < 4; i++) begin
            w[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return w;
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] w = '0;
        for (int i = 0; i < 4; i++) w[4*i +: 4] = 4'($urandom_range(0, 9));
        return w;
    endfunction

    // Reference model: plain decimal add with carry, or subtract with borrow.
    task automatic model_job(input int n, input bit cin, input bit sb);
        bit s = sb && SUB_EN;
        int c = s ? 0 : int'(cin);
        int t;
        for (int k = 0; k < n; k++) begin
            if (!s) begin
                t = bcd2int(a_w[k]) + bcd2int(b_w[k]) + c;
                c = t / 10000;
                t = t % 10000;
            end else begin
                t = bcd2int(a_w[k]) - bcd2int(b_w[k]) - c;
                if (t < 0) begin
                    t = t + 10000;
                    c = 1;
                end else begin
                    c = 0;
                end
            end
            exp_q.push_back({(k == n - 1), int2bcd(t)});
        end
        exp_carry = c[0];
    endtask

    task automatic set_vec(input int i, input int n, input bit cin, input bit sb, input int mode,
                           input bit bs, input bit ns,
                           input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                           input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2,
                           input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2,
                           input bit co);
        vecs[i].n = n; vecs[i].cin = cin; vecs[i].sb = sb; vecs[i].mode = mode;
        vecs[i].bstart = bs; vecs[i].need_sub = ns;
        vecs[i].a[0] = a0; vecs[i].a[1] = a1; vecs[i].a[2] = a2;
        vecs[i].b[0] = b0; vecs[i].b[1] = b1; vecs[i].b[2] = b2;
        vecs[i].s[0] = s0; vecs[i].s[1] = s1; vecs[i].s[2] = s2;
        vecs[i].co = co;
    endtask

    // Driver: runs one job from a_w/b_w and checks against exp_q/exp_carry.
    task automatic run_job(input int n, input bit cin, input bit sb, input int mode, input bit bstart);
        int idx = 0;
        int got = 0;
        int cyc = 0;
        int stall_seen = 0;
        bit prev_hold = 1'b0;
        logic [16:0] held = '0;
        logic [16:0] e;
        @(negedge clk);
        start = 1'b1; len = LEN_W'(n); cin_init = cin; sub = sb;
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (got < n && cyc < 400) begin
            if (bstart && cyc == 0) begin
                start = 1'b1; len = 4'd7; in_valid = 1'b0;
            end else begin
                start = 1'b0;
                in_valid = (idx < n) && (mode != 1 || $urandom_range(0, 3) != 0);
            end
            in_a = (idx < n) ? a_w[idx] : 16'h0000;
            in_b = (idx < n) ? b_w[idx] : 16'h0000;
            if (mode == 1) out_ready = ($urandom_range(0, 2) != 0);
            else if (mode == 2) out_ready = (stall_seen >= 4);
            else out_ready = 1'b1;
            #1;
            if (prev_hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_word", 32'({out_last, out_sum}), 32'(held));
            end
            if (mode == 2 && out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL extra_word: got %0h expected no word", {out_last, out_sum});
                end else begin
                    e = exp_q.pop_front();
                    check("sum_word", 32'({out_last, out_sum}), 32'(e));
                end
                got++;
            end
            prev_hold = out_valid && !out_ready;
            held = {out_last, out_sum};
            if (mode == 2 && out_valid && got == 0) stall_seen++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        if (got < n) begin
            check("job_timeout", 32'(got), 32'(n));
            exp_q.delete();
        end else begin
            if (mode == 0 && !bstart) check("throughput_cycles", 32'(cyc), 32'(n + 1));
            check("done_pulse", 32'(done), 32'd1);
            check("carry_out", 32'(carry_out), 32'(exp_carry));
            check("busy_after", 32'(busy), 32'd0);
            @(negedge clk);
            check("done_single", 32'(done), 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_sum"}, 32'(out_sum), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_carry_out"}, 32'(carry_out), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        int n;
        bit cin, sb;
        rst = 1'b1; start = 1'b0; len = '0; cin_init = 1'b0; sub = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Directed vectors; the last one leaves carry_out=1 for the reset test.
        set_vec(0, 1, 0, 0, 0, 0, 0, 16'h5000, 16'h0, 16'h0, 16'h5000, 16'h0, 16'h0,
                16'h0000, 16'h0, 16'h0, 1);
        set_vec(1, 2, 0, 0, 0, 1, 0, 16'h9999, 16'h0000, 16'h0, 16'h0001, 16'h0000, 16'h0,
                16'h0000, 16'h0001, 16'h0, 0);
        set_vec(2, 3, 1, 0, 2, 0, 0, 16'h1234, 16'h0999, 16'h0000, 16'h4321, 16'h0001, 16'h0000,
                16'h5556, 16'h1000, 16'h0000, 0);
        set_vec(3, 1, 0, 1, 0, 0, 1, 16'h0001, 16'h0, 16'h0, 16'h0002, 16'h0, 16'h0,
                16'h9999, 16'h0, 16'h0, 1);
        set_vec(4, 1, 1, 1, 0, 0, 1, 16'h0050, 16'h0, 16'h0, 16'h0020, 16'h0, 16'h0,
                16'h0030, 16'h0, 16'h0, 0);
        set_vec(5, 1, 1, 0, 0, 0, 0, 16'h9999, 16'h0, 16'h0, 16'h9999, 16'h0, 16'h0,
                16'h9999, 16'h0, 16'h0, 1);

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].need_sub && !SUB_EN) continue;
            exp_q.delete();
            for (int k = 0; k < vecs[v].n; k++) begin
                a_w[k] = vecs[v].a[k];
                b_w[k] = vecs[v].b[k];
                exp_q.push_back({(k == vecs[v].n - 1), vecs[v].s[k]});
            end
            exp_carry = vecs[v].co;
            run_job(vecs[v].n, vecs[v].cin, vecs[v].sb, vecs[v].mode, vecs[v].bstart);
        end

        // start with len=0 in IDLE is ignored.
        @(negedge clk);
        start = 1'b1; len = '0; cin_init = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("len0_done", 32'(done), 32'd0);
        check("len0_carry", 32'(carry_out), 32'd1);

        // Reset in RUN after 1 of 3 words.
        start = 1'b1; len = 4'd3; cin_init = 1'b0; sub = 1'b0;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_a = 16'h0001; in_b = 16'h0001; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        exp_q.delete();
        a_w[0] = 16'h0001; b_w[0] = 16'h0001;
        exp_q.push_back({1'b1, 16'h0002});
        exp_carry = 1'b0;
        run_job(1, 0, 0, 0, 0);

        // Randomized jobs against the reference model.
        for (int j = 0; j < 25; j++) begin
            n = $urandom_range(1, 8);
            cin = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            for (int k = 0; k < n; k++) begin
                a_w[k] = rand_bcd();
                b_w[k] = rand_bcd();
            end
            exp_q.delete();
            model_job(n, cin, sb);
            run_job(n, cin, sb, 1, 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
